// File: rtl/amstrad_mem_upload_pkg.sv
// Shared upload/download page map: 16 KB host pages onto SDRAM bank/page bases.
// Pure combinational helpers; no state, no latency, no flow control.
package amstrad_mem_upload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_RAM   = 8'd1;
    localparam int         MAP_PAGES = 8;

    localparam logic [8:0] ROM_PAGE_BASE [0:3] = '{9'h000, 9'h100, 9'h107, 9'h1FF};

    typedef struct packed {
        logic       valid;
        logic       bank;
        logic [8:0] base;
    } page_map_t;

    // ROM pages 4-7 reuse the four bases of pages 0-3 in the other bank.
    function automatic page_map_t page_map(
        input logic [7:0]  index,
        input logic [10:0] page,
        input logic        ram_bank
    );
        page_map_t m;
        m = '0;
        if (page < 11'(MAP_PAGES)) begin
            case (index)
                IDX_ROM: begin
                    m.valid = 1'b1;
                    m.bank  = page[2];
                    m.base  = ROM_PAGE_BASE[page[1:0]];
                end
                IDX_RAM: begin
                    m.valid = 1'b1;
                    m.bank  = ram_bank;
                    m.base  = {6'b0, page[2:0]};
                end
                default: ;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/amstrad_mem_upload.sv
// Prefetching SDRAM read-back for the host upload channel; byte ready one cycle after mem_ack
// (pad bytes two cycles after the strobe); ioctl_wait holds the host off while a fetch is pending.
module amstrad_mem_upload
    import amstrad_mem_upload_pkg::*;
#(
    parameter int         PAGES    = 8,
    parameter logic [7:0] PAD_BYTE = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic        ram_bank,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    output logic        mem_bank,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dout
);

    state_t      state, state_nxt;
    logic        upload_q;
    logic        start_pend, start_pend_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  din_nxt;
    logic        wait_nxt;
    logic        req_nxt;
    logic [22:0] addr_nxt;
    logic        bank_nxt;

    logic        start;
    logic        strobe;
    logic [24:0] launch_addr;
    logic [7:0]  launch_idx;
    logic [10:0] launch_page;
    page_map_t   launch_map;
    logic        launch_valid;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            upload_q   <= 1'b0;
            start_pend <= 1'b0;
            idx        <= 8'd0;
            ioctl_din  <= 8'hFF;
            ioctl_wait <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 23'd0;
            mem_bank   <= 1'b0;
        end else begin
            state      <= state_nxt;
            upload_q   <= ioctl_upload;
            start_pend <= start_pend_nxt;
            idx        <= idx_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            mem_req    <= req_nxt;
            mem_addr   <= addr_nxt;
            mem_bank   <= bank_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        start_pend_nxt = start_pend;
        idx_nxt        = idx;
        din_nxt        = ioctl_din;
        wait_nxt       = ioctl_wait;
        req_nxt        = mem_req;
        addr_nxt       = mem_addr;
        bank_nxt       = mem_bank;

        // A session start seen during DRAIN is remembered and launched from IDLE.
        start        = ioctl_upload && (!upload_q || start_pend);
        strobe       = ioctl_upload && ioctl_rd && !ioctl_wait;
        launch_addr  = start ? 25'd0 : ioctl_addr + 25'd1;
        launch_idx   = start ? ioctl_index : idx;
        launch_page  = launch_addr[24:14];
        launch_map   = page_map(launch_idx, launch_page, ram_bank);
        launch_valid = launch_map.valid && (int'(launch_page) < PAGES);

        case (state)
            ST_IDLE: begin
                start_pend_nxt = 1'b0;
                if (start || strobe) begin
                    if (start) begin
                        idx_nxt = ioctl_index;
                    end
                    wait_nxt = 1'b1;
                    if (launch_valid) begin
                        req_nxt   = 1'b1;
                        addr_nxt  = {launch_map.base, launch_addr[13:0]};
                        bank_nxt  = launch_map.bank;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end

            ST_REQ: begin
                if (!ioctl_upload) begin
                    wait_nxt = 1'b0;
                    if (mem_ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (mem_ack) begin
                    din_nxt   = mem_dout;
                    wait_nxt  = 1'b0;
                    req_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            ST_DATA: begin
                wait_nxt  = 1'b0;
                state_nxt = ST_IDLE;
                if (ioctl_upload) begin
                    din_nxt = PAD_BYTE;
                end
            end

            ST_DRAIN: begin
                if (ioctl_upload && !upload_q) begin
                    start_pend_nxt = 1'b1;
                end
                if (mem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
                wait_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_amstrad_mem_upload.sv
// Directed bench for amstrad_mem_upload: vector table plus hand sequences for delay, abort and reset.
module tb_amstrad_mem_upload;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ram_bank;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_bank;
    logic        mem_ack  = 1'b0;
    logic [7:0]  mem_dout = 8'h00;

    int checks = 0;
    int errors = 0;
    int ack_delay = 1;
    int req_cycles = 0;
    bit stray_ack = 1'b0;

    logic [7:0] mem [logic [23:0]];
    logic [8:0] rom_base [0:3] = '{9'h000, 9'h100, 9'h107, 9'h1FF};

    amstrad_mem_upload #(.PAGES(8), .PAD_BYTE(8'hFF)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .ram_bank     (ram_bank),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_bank     (mem_bank),
        .mem_ack      (mem_ack),
        .mem_dout     (mem_dout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] mem_read(input logic bank, input logic [22:0] addr);
        logic [23:0] key;
        key = {bank, addr};
        if (mem.exists(key)) return mem[key];
        return addr[7:0] ^ 8'h5A ^ {7'b0, bank};
    endfunction

    // Arbiter model: ack in the ack_delay-th cycle that mem_req is seen high.
    always @(posedge clk_sys) begin
        #1;
        if (mem_req) begin
            req_cycles = req_cycles + 1;
            if (req_cycles >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_dout = mem_read(mem_bank, mem_addr);
            end else begin
                mem_ack  = 1'b0;
                mem_dout = 8'h00;
            end
        end else begin
            req_cycles = 0;
            mem_ack    = stray_ack;
            mem_dout   = stray_ack ? 8'h3C : 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_sys);
            #1;
            if (!ioctl_wait) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_session(input logic [7:0] idx, input logic rb, output bit ok);
        ioctl_upload = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        ioctl_index  = idx;
        ram_bank     = rb;
        ioctl_upload = 1'b1;
        wait_ready(ok);
    endtask

    task automatic fetch(input logic [24:0] target, output bit ok);
        ioctl_addr = target - 25'd1;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        wait_ready(ok);
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic        rbank;
        logic [24:0] target;
        logic        mapped;
        logic [22:0] maddr;
        logic        mbank;
        logic [7:0]  first;
        logic [7:0]  din;
    } vec_t;

    localparam int NV = 12;
    vec_t v [NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        bit ok;
        int n;
        logic [13:0] off;

        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'd0;
        ram_bank     = 1'b0;

        v[0]  = '{8'd0, 1'b0, 25'h08005, 1'b1, 23'h41C005, 1'b0, 8'h00, 8'h07};
        v[1]  = '{8'd0, 1'b0, 25'h10000, 1'b1, 23'h000000, 1'b1, 8'h00, 8'h5B};
        v[2]  = '{8'd0, 1'b0, 25'h04010, 1'b1, 23'h400010, 1'b0, 8'h00, 8'h11};
        v[3]  = '{8'd0, 1'b0, 25'h1FFFF, 1'b1, 23'h7FFFFF, 1'b1, 8'h00, 8'hA4};
        v[4]  = '{8'd1, 1'b0, 25'h20000, 1'b0, 23'h000000, 1'b0, 8'h00, 8'hFF};
        v[5]  = '{8'd1, 1'b1, 25'h0C123, 1'b1, 23'h00C123, 1'b1, 8'h5B, 8'h78};
        v[6]  = '{8'd1, 1'b0, 25'h1C000, 1'b1, 23'h01C000, 1'b0, 8'h00, 8'h5A};
        v[7]  = '{8'd7, 1'b0, 25'h00010, 1'b0, 23'h000000, 1'b0, 8'hFF, 8'hFF};
        v[8]  = '{8'd0, 1'b0, 25'h00000, 1'b1, 23'h000000, 1'b0, 8'h00, 8'h00};
        v[9]  = '{8'd0, 1'b0, 25'h30000, 1'b0, 23'h000000, 1'b0, 8'h00, 8'hFF};
        v[10] = '{8'd1, 1'b1, 25'h00003, 1'b1, 23'h000003, 1'b1, 8'h5B, 8'h58};
        v[11] = '{8'd2, 1'b0, 25'h00100, 1'b0, 23'h000000, 1'b0, 8'hFF, 8'hFF};

        for (int p = 0; p < 4; p++) begin
            for (int o = 0; o < 16384; o++) begin
                off = 14'(o);
                mem[{1'b0, rom_base[p], off}] = off[7:0] ^ 8'(p);
            end
        end

        #1;
        chk("rst_din", ioctl_din, 8'hFF);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_bank", mem_bank, 0);
        #21;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_session(v[i].idx, v[i].rbank, ok);
            chk("start_rdy", ok, 1);
            chk("first_din", ioctl_din, v[i].first);
            ioctl_addr = v[i].target - 25'd1;
            ioctl_rd   = 1'b1;
            @(posedge clk_sys);
            #1;
            ioctl_rd = 1'b0;
            chk("vec_wait", ioctl_wait, 1);
            chk("vec_req", mem_req, v[i].mapped);
            if (v[i].mapped) begin
                chk("vec_addr", mem_addr, v[i].maddr);
                chk("vec_bank", mem_bank, v[i].mbank);
                wait_ready(ok);
                chk("vec_rdy", ok, 1);
            end else begin
                @(posedge clk_sys);
                #1;
                chk("pad_wait", ioctl_wait, 0);
                chk("pad_req", mem_req, 0);
            end
            chk("vec_din", ioctl_din, v[i].din);
        end

        // ROM read-back over pages 0-3 of bank 0.
        start_session(8'd0, 1'b0, ok);
        chk("rom_start", ioctl_din, 8'h00);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 128; k++) begin
                off = 14'(k * 129);
                fetch({11'(p), off}, ok);
                chk("rom_rdy", ok, 1);
                chk("rom_din", ioctl_din, off[7:0] ^ 8'(p));
            end
        end

        // Delayed ack with an illegal strobe while waiting.
        ack_delay  = 9;
        ioctl_addr = 25'h0401F;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (!mem_req) break;
            n++;
            chk("dly_addr", mem_addr, 23'h400020);
            chk("dly_wait", ioctl_wait, 1);
            if (c == 4) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 25'h00FFF;
            end else begin
                ioctl_rd = 1'b0;
            end
            @(posedge clk_sys);
            #1;
        end
        ioctl_rd = 1'b0;
        chk("dly_cycles", n, 9);
        chk("dly_wait_clr", ioctl_wait, 0);
        chk("dly_din", ioctl_din, 8'h21);
        ack_delay = 1;

        // Ack with no request outstanding.
        stray_ack = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        stray_ack = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("stray_din", ioctl_din, 8'h21);
        chk("stray_wait", ioctl_wait, 0);
        chk("stray_req", mem_req, 0);

        // Index is latched at session start.
        ioctl_index = 8'd7;
        fetch(25'h04005, ok);
        chk("latch_rdy", ok, 1);
        chk("latch_din", ioctl_din, 8'h04);

        // Abort while a request is outstanding.
        fetch(25'h00005, ok);
        chk("abort_pre", ioctl_din, 8'h05);
        ack_delay  = 6;
        ioctl_addr = 25'h00105;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (!mem_req) break;
            n++;
            if (n == 2) ioctl_upload = 1'b0;
            @(posedge clk_sys);
            #1;
        end
        chk("abort_cycles", n, 6);
        chk("abort_req", mem_req, 0);
        chk("abort_din", ioctl_din, 8'h05);

        // Asynchronous reset during a fetch.
        ack_delay = 50;
        @(posedge clk_sys);
        #1;
        ioctl_index  = 8'd0;
        ioctl_upload = 1'b1;
        repeat (3) @(posedge clk_sys);
        #2;
        chk("rst_mid_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_din", ioctl_din, 8'hFF);
        chk("arst_wait", ioctl_wait, 0);
        chk("arst_addr", mem_addr, 0);
        ioctl_upload = 1'b0;
        #10;
        reset     = 1'b0;
        ack_delay = 1;
        @(posedge clk_sys);
        #1;
        ioctl_upload = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_bank", mem_bank, 0);
        wait_ready(ok);
        chk("post_rst_rdy", ok, 1);
        chk("post_rst_din", ioctl_din, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amstrad_mem_upload.md
# amstrad_mem_upload

Read-back engine for host uploads: streams bytes out of SDRAM to the MiST I/O controller's upload channel, the reverse direction of the ROM download path. It fetches data using the same 16 KB page map the loader uses to write it. It sits between the mist_io ioctl upload port and a dedicated read port of the SDRAM arbiter. The block keeps one prefetched byte so the host always finds `ioctl_din` valid when it strobes.

## Interface
Parameters:
- `PAGES`, 8: number of 16 KB pages exposed per upload (128 KB total).
- `PAD_BYTE`, 8'hFF: value returned for unmapped pages.

Ports:
- `clk_sys`  in  1  system clock (all logic on rising edge).
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_upload`  in  1  high for the whole upload session.
- `ioctl_index`  in  8  region select: 0 = ROM map, 1 = RAM map; any other value returns pad bytes.
- `ioctl_rd`  in  1  one-cycle strobe: the byte at `ioctl_addr` has been consumed.
- `ioctl_addr`  in  25  byte address of the byte just consumed.
- `ioctl_din`  out  8  current byte for the host.
- `ioctl_wait`  out  1  high while `ioctl_din` is not yet valid; the host must not strobe while it is high.
- `ram_bank`  in  1  SDRAM bank used for the RAM map (the current model).
- `mem_req`  out  1  read request, level.
- `mem_addr`  out  23  SDRAM byte address.
- `mem_bank`  out  1  SDRAM bank.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_dout` is valid in the same cycle.
- `mem_dout`  in  8  read data.

## Operation
Page map, with page = addr[24:14] and offset = addr[13:0]:
- ROM map, pages 0–3: `mem_addr[22:14]` = 9'h000 / 9'h100 / 9'h107 / 9'h1FF, `mem_bank` = 0.
- ROM map, pages 4–7: same four page bases, `mem_bank` = 1.
- RAM map, page p < 8: `mem_addr[22:14]` = {6'b0, p[2:0]}, `mem_bank` = `ram_bank`.
- Any page ≥ `PAGES`, or any other index: no memory access; the byte is `PAD_BYTE`.

State machine IDLE → REQ → DATA → IDLE, plus DRAIN:
- IDLE: on the rising edge of `ioctl_upload`, set fetch address to 0 and enter REQ.
- Mid-session IDLE: an `ioctl_rd` strobe sets fetch address = `ioctl_addr` + 1 (25-bit add, wraps to 0) and enters REQ.
- REQ, mapped address: assert `mem_req` with the mapped address and wait for `mem_ack`.
- REQ, unmapped address: skip the memory access and go straight to DATA with `PAD_BYTE`.
- DATA: load `ioctl_din`, clear `ioctl_wait`, return to IDLE.
- `ioctl_upload` falls while `mem_req` is outstanding: go to DRAIN, keep `mem_req` high until `mem_ack`, discard the data, go to IDLE.
- `ioctl_upload` falls in any other state: go to IDLE immediately.
- `ioctl_wait` is set on session start and on every accepted strobe.
- A strobe while `ioctl_wait` = 1 is a protocol violation. It is ignored, and `ioctl_din` keeps its old value.
- `ioctl_index` is latched at session start; later changes are ignored until the next session.
- `mem_addr` and `mem_bank` stay stable while `mem_req` is high.

## Timing
- Reset values: `ioctl_din` = 8'hFF, `ioctl_wait` = 0, `mem_req` = 0, `mem_addr` = 0, `mem_bank` = 0, state = IDLE.
- Strobe or session start at cycle t: `ioctl_wait` = 1 and `mem_req` = 1 at t+1.
- `mem_ack` at cycle a: `ioctl_din` updated and `ioctl_wait` = 0 at a+1; `mem_req` = 0 at a+1.
- Unmapped byte: `ioctl_din` = `PAD_BYTE` and `ioctl_wait` = 0 at t+2.
- At most one outstanding request at any time.
- `mem_ack` while `mem_req` is low is ignored.
- Asynchronous reset mid-fetch: all outputs drop to their reset values immediately. The arbiter is expected to cancel the in-flight read on its own reset.

## Structure
- Shared package holds:
  - the state enum;
  - constants ROM_PAGE_BASE[0:3] = {9'h000, 9'h100, 9'h107, 9'h1FF};
  - region index constants;
  - a pure function `page_map(index, page, ram_bank)` returning {valid, bank, base}. The same function is reused by the download-side mapping.
- Single module, no sub-module.

## Test plan
- ROM map read-back:
  - Preload ROM pages 0–3 bank 0 with pattern addr[7:0] ^ page; upload index 0 with 64 K strobes.
  - Each `ioctl_din` matches the pattern.
  - `mem_addr` for byte 0x8005 is {9'h107, 14'h0005}.
- Bank select: upload index 0 byte 0x10000 → `mem_bank` = 1, `mem_addr` = 23'h000000.
- Pad region:
  - Index 1, address 0x20000 → `ioctl_din` = 8'hFF at t+2, no `mem_req` pulse.
  - Index 7 → all bytes 8'hFF.
- Delayed ack:
  - Arbiter acks after 9 cycles → `mem_req` held high 9 cycles with stable address.
  - `ioctl_wait` stays high until the cycle after the ack.
- Abort: drop `ioctl_upload` during an outstanding request → DRAIN; `mem_req` stays high until the ack, then goes low; `ioctl_din` is unchanged.
- Reset mid-fetch:
  - Assert `reset` asynchronously → `mem_req` = 0 and `ioctl_din` = 8'hFF with no clock edge.
  - A new session afterwards fetches address 0.
